// File: rtl/mul_pkg.sv
// Shared types and constants for the shift-add multiplier.
package mul_pkg;

  localparam int MUL_W     = 8;
  localparam int MUL_ITERS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/adder8bit.sv
// Lab-series 8-bit ripple adder with carry in/out.
module adder8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] Sum,
  output logic       Cout
);

  // Full-width add; the carry lands in the ninth bit.
  assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {8'b0, Cin};

endmodule

// File: rtl/mul8_shift_add.sv
// Sequential 8x8 unsigned shift-add multiplier with a start/busy/done handshake.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; a/b captured on the accepting edge
// CALC  | eight add-and-shift iterations through adder8bit
// DONE  | one-cycle done pulse, product already valid
module mul8_shift_add
  import mul_pkg::*;
#(
  parameter int WIDTH  = MUL_W,
  parameter int ITER_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  // The adder instance is hard-wired to 8 bits, so any other width is illegal.
  if (WIDTH != 8) begin : g_width_check
    $error("mul8_shift_add: WIDTH must be 8");
  end

  mul_state_t        state, state_nxt;
  logic [WIDTH-1:0]  hi, lo, mcand;
  logic [ITER_W-1:0] cnt;
  logic              load, step, last;

  logic [WIDTH-1:0]  add_b;
  logic [WIDTH-1:0]  sum;
  logic              cout;

  assign add_b = lo[0] ? mcand : '0;
  assign last  = (cnt == ITER_W'(MUL_ITERS - 1));

  adder8bit u_add (
    .A    (hi),
    .B    (add_b),
    .Cin  (1'b0),
    .Sum  (sum),
    .Cout (cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, add-and-shift, and product latch on the final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (load) begin
      hi    <= '0;
      lo    <= b;
      mcand <= a;
      cnt   <= '0;
    end else if (step) begin
      // {cout,sum,lo} shifted right by one; cout lands in the top of hi.
      hi  <= {cout, sum[WIDTH-1:1]};
      lo  <= {sum[0], lo[WIDTH-1:1]};
      cnt <= cnt + 1'b1;
      if (last) product <= {cout, sum, lo[WIDTH-1:1]};
    end
  end

endmodule
